// File: rtl/mux41_pkg.sv
// rtl/mux41_pkg.sv - shared types and constants for the 4:1 mux scanner
package mux41_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/mux41_scan_cnt.sv
// rtl/mux41_scan_cnt.sv - per-channel dwell counter with terminal count and optional vote-window flags
//
// Optional feature macro: MUX41_SCAN_MAJORITY_EN (adds vote_a/vote_b flags).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   run    : count this cycle; when low the counter is cleared
//   tc     : counter equals DWELL-1 (last cycle on the current channel)
//   vote_a : counter equals DWELL-3 (first majority sample)
//   vote_b : counter equals DWELL-2 (second majority sample)
module mux41_scan_cnt #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
`ifdef MUX41_SCAN_MAJORITY_EN
    output logic vote_a,
    output logic vote_b,
`endif
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == CNT_W'(DWELL - 1));

`ifdef MUX41_SCAN_MAJORITY_EN
    assign vote_a = (cnt_q == CNT_W'(DWELL - 3));
    assign vote_b = (cnt_q == CNT_W'(DWELL - 2));
`endif

    // Wraps to zero at terminal count so each channel starts its dwell fresh;
    // held at zero whenever not scanning so a new scan always starts at 0.
    always_comb begin
        cnt_d = '0;
        if (run && !tc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux41_scanner.sv
// rtl/mux41_scanner.sv - timed select sequencer and 4-bit sampler for a 4:1 one-bit multiplexer
//
// Optional feature macro: MUX41_SCAN_MAJORITY_EN (2-of-3 majority sampling per channel).
// Ports:
//   CLK, RST_N : rising-edge clock, synchronous active-low reset
//   START      : level, begins a scan when idle
//   CONT       : at scan end, start the next scan immediately
//   ABORT      : drop the scan in progress without updating DATA
//   MUX_OUT    : multiplexer output
//   SEL        : multiplexer select (also the current channel)
//   DATA       : last completed scan, DATA[i] sampled with SEL == i
//   VALID      : one-cycle strobe, DATA updated
//   BUSY       : scan in progress
module mux41_scanner
    import mux41_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              CONT,
    input  logic              ABORT,
    input  logic              MUX_OUT,
    output logic [SEL_W-1:0]  SEL,
    output logic [NUM_CH-1:0] DATA,
    output logic              VALID,
    output logic              BUSY
);

    if ((1 << CNT_W) <= DWELL) begin : g_cnt_w_chk
        $error("mux41_scanner: CNT_W too narrow for DWELL");
    end

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic run;
    logic tc;
    logic sample;

    assign run = (state_q == SCAN) && !ABORT;

`ifdef MUX41_SCAN_MAJORITY_EN
    if (DWELL < 3) begin : g_dwell_chk
        $error("mux41_scanner: majority sampling needs DWELL >= 3");
    end

    logic       vote_a, vote_b;
    logic [1:0] vote_q, vote_d;

    mux41_scan_cnt #(.DWELL(DWELL), .CNT_W(CNT_W)) u_cnt (
        .clk    (CLK),
        .rst_n  (RST_N),
        .run    (run),
        .vote_a (vote_a),
        .vote_b (vote_b),
        .tc     (tc)
    );

    // The two earlier samples wait in vote_q; the third is taken live at tc.
    always_comb begin
        vote_d = vote_q;
        if (run && vote_a) vote_d[0] = MUX_OUT;
        if (run && vote_b) vote_d[1] = MUX_OUT;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) vote_q <= 2'b00;
        else        vote_q <= vote_d;
    end

    assign sample = (vote_q[0] & vote_q[1]) | (vote_q[0] & MUX_OUT) | (vote_q[1] & MUX_OUT);
`else
    mux41_scan_cnt #(.DWELL(DWELL), .CNT_W(CNT_W)) u_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .run   (run),
        .tc    (tc)
    );

    assign sample = MUX_OUT;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (START && !ABORT) begin
                    state_d  = SCAN;
                    sel_d    = '0;
                    shadow_d = '0;
                end
            end
            SCAN: begin
                if (ABORT) begin
                    state_d  = IDLE;
                    sel_d    = '0;
                    shadow_d = '0;
                end else if (tc) begin
                    shadow_d[sel_q] = sample;
                    if (sel_q == SEL_W'(NUM_CH - 1)) begin
                        // Word includes the bit captured on this same edge.
                        data_d  = shadow_d;
                        valid_d = 1'b1;
                        sel_d   = '0;
                        if (!CONT) state_d = IDLE;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign SEL   = sel_q;
    assign DATA  = data_q;
    assign VALID = valid_q;
    assign BUSY  = (state_q == SCAN);

endmodule

// File: tb/tb_mux41_scanner.sv
// tb/tb_mux41_scanner.sv - directed self-checking bench for mux41_scanner
module tb_mux41_scanner;

`ifdef MUX41_SCAN_MAJORITY_EN
    localparam int DW_B = 3;
`else
    localparam int DW_B = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT A: DWELL = 4
    logic       rst_a = 1'b0, start_a = 1'b0, cont_a = 1'b0, abort_a = 1'b0;
    logic [3:0] in_a  = 4'b0000;
    logic       mux_a;
    logic [1:0] sel_a;
    logic [3:0] data_a;
    logic       valid_a, busy_a;

    // DUT B: short dwell
    logic       rst_b = 1'b0, start_b = 1'b0, cont_b = 1'b0, abort_b = 1'b0;
    logic [3:0] in_b  = 4'b0000;
    logic       mux_b;
    logic [1:0] sel_b;
    logic [3:0] data_b;
    logic       valid_b, busy_b;

    assign mux_a = in_a[sel_a];
    assign mux_b = in_b[sel_b];

    mux41_scanner #(.DWELL(4), .CNT_W(8)) u_dut_a (
        .CLK(clk), .RST_N(rst_a), .START(start_a), .CONT(cont_a), .ABORT(abort_a),
        .MUX_OUT(mux_a), .SEL(sel_a), .DATA(data_a), .VALID(valid_a), .BUSY(busy_a)
    );

    mux41_scanner #(.DWELL(DW_B), .CNT_W(8)) u_dut_b (
        .CLK(clk), .RST_N(rst_b), .START(start_b), .CONT(cont_b), .ABORT(abort_b),
        .MUX_OUT(mux_b), .SEL(sel_b), .DATA(data_b), .VALID(valid_b), .BUSY(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // START sampled at "edge 0".
    task automatic pulse_a(input string tag);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk({tag, "_busy0"}, 32'(busy_a), 32'd1);
        chk({tag, "_sel0"},  32'(sel_a),  32'd0);
    endtask

    // Runs edges 1..16 of a CONT=0 scan on DUT A, checking SEL/VALID/BUSY each cycle.
    task automatic scan_a(input string tag, input logic [3:0] exp);
        for (int j = 1; j <= 16; j++) begin
            step();
            chk($sformatf("%s_sel_e%0d", tag, j),   32'(sel_a),   (j < 16) ? 32'(j / 4) : 32'd0);
            chk($sformatf("%s_valid_e%0d", tag, j), 32'(valid_a), (j == 16) ? 32'd1 : 32'd0);
            chk($sformatf("%s_busy_e%0d", tag, j),  32'(busy_a),  (j < 16) ? 32'd1 : 32'd0);
        end
        chk({tag, "_data"}, 32'(data_a), 32'(exp));
        step();
        chk({tag, "_valid_after"}, 32'(valid_a), 32'd0);
    endtask

    initial begin
        step();
        step();
        chk("rst_sel",   32'(sel_a),   32'd0);
        chk("rst_data",  32'(data_a),  32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_busy",  32'(busy_a),  32'd0);
        chk("rst_b_busy", 32'(busy_b), 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Single scan
        in_a = 4'b1010;
        pulse_a("t1");
        scan_a("t1", 4'b1010);

        // Reset mid-scan at edge 6, then a normal scan
        in_a = 4'b0101;
        pulse_a("t4");
        repeat (5) step();
        rst_a = 1'b0;
        step();
        chk("t4_rst_sel",   32'(sel_a),   32'd0);
        chk("t4_rst_data",  32'(data_a),  32'd0);
        chk("t4_rst_valid", 32'(valid_a), 32'd0);
        chk("t4_rst_busy",  32'(busy_a),  32'd0);
        rst_a = 1'b1;
        in_a  = 4'b0011;
        pulse_a("t4b");
        scan_a("t4b", 4'b0011);

        // Abort at edge 10 after DATA cleared by reset
        rst_a = 1'b0;
        step();
        rst_a = 1'b1;
        in_a  = 4'b1111;
        pulse_a("t3");
        repeat (9) step();
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("t3_busy", 32'(busy_a),  32'd0);
        chk("t3_sel",  32'(sel_a),   32'd0);
        chk("t3_val",  32'(valid_a), 32'd0);
        chk("t3_data", 32'(data_a),  32'd0);
        for (int j = 0; j < 8; j++) begin
            step();
            chk($sformatf("t3_quiet%0d", j), 32'(valid_a), 32'd0);
        end
        // Abort on the scan-end edge
        pulse_a("t3b");
        repeat (15) step();
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("t3b_val",  32'(valid_a), 32'd0);
        chk("t3b_busy", 32'(busy_a),  32'd0);
        chk("t3b_data", 32'(data_a),  32'd0);
        step();
        chk("t3b_val2", 32'(valid_a), 32'd0);

        // Continuous mode; input changes right after channel 2 of scan 2 is sampled
        cont_a = 1'b1;
        in_a   = 4'b0110;
        pulse_a("t2");
        for (int j = 1; j <= 32; j++) begin
            step();
            chk($sformatf("t2_valid_e%0d", j), 32'(valid_a), (j == 16 || j == 32) ? 32'd1 : 32'd0);
            chk($sformatf("t2_busy_e%0d", j),  32'(busy_a),  32'd1);
            if (j == 16) chk("t2_data1", 32'(data_a), 32'h6);
            if (j == 28) in_a = 4'b1001;
        end
        chk("t2_data2", 32'(data_a), 32'hE);
        cont_a = 1'b0;
        repeat (16) step();
        chk("t2_valid3", 32'(valid_a), 32'd1);
        chk("t2_data3",  32'(data_a),  32'h9);
        chk("t2_busy3",  32'(busy_a),  32'd0);

        // One-cycle glitch on IN[1] at counter value 1 of channel 1
        in_a = 4'b0010;
        pulse_a("t6");
        repeat (5) step();
        in_a = 4'b0000;
        step();
        in_a = 4'b0010;
        repeat (10) step();
        chk("t6_valid", 32'(valid_a), 32'd1);
        chk("t6_data",  32'(data_a),  32'h2);

        // Short dwell on DUT B
        in_b    = 4'b0011;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("t5_sel0",  32'(sel_b),  32'd0);
        chk("t5_busy0", 32'(busy_b), 32'd1);
        for (int j = 1; j <= 4 * DW_B; j++) begin
            step();
            chk($sformatf("t5_sel_e%0d", j),   32'(sel_b),   (j < 4 * DW_B) ? 32'(j / DW_B) : 32'd0);
            chk($sformatf("t5_valid_e%0d", j), 32'(valid_b), (j == 4 * DW_B) ? 32'd1 : 32'd0);
            chk($sformatf("t5_busy_e%0d", j),  32'(busy_b),  (j < 4 * DW_B) ? 32'd1 : 32'd0);
        end
        chk("t5_data", 32'(data_b), 32'h3);
        step();
        chk("t5_valid_after", 32'(valid_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux41_scanner.md
# mux41_scanner

Sequencer placed directly upstream of the 4:1 one-bit multiplexer. Drives the multiplexer's 2-bit select, waits a programmable settle time on each channel, and samples the multiplexer output. After scanning all four channels it presents the four sampled bits as one parallel word with a one-cycle valid strobe. It turns the combinational mux into a timed, registered 4-bit acquisition path.

## Interface
- DWELL, default 4: cycles spent on each channel; legal range 1..255 (3..255 when MUX41_SCAN_MAJORITY_EN is defined).
- CNT_W, default 8: width of the dwell counter; must satisfy 2^CNT_W > DWELL.
- CLK  in  1  single clock; all logic is rising-edge.
- RST_N  in  1  synchronous, active-low reset, sampled on the CLK rising edge.
- START  in  1  level; sampled in IDLE to begin a scan.
- CONT  in  1  when high at scan end, the next scan starts immediately.
- ABORT  in  1  synchronous abort of a scan in progress.
- MUX_OUT  in  1  output of the 4:1 multiplexer.
- SEL  out  2  select to the multiplexer.
- DATA  out  4  last completed scan; DATA[i] holds the sample taken with SEL == i.
- VALID  out  1  one-cycle strobe: DATA updated this cycle.
- BUSY  out  1  high while state is SCAN.

## Operation
- Reset values (RST_N low at an edge): state IDLE, SEL = 2'b00, dwell counter = 0, shadow = 4'b0000, DATA = 4'b0000, VALID = 0, BUSY = 0.
- Two states: IDLE and SCAN. The current channel is SEL itself; there is no separate channel register.
- IDLE -> SCAN when START = 1 and ABORT = 0. On that edge SEL = 0 and the counter is cleared.
- In SCAN, the counter increments every cycle.
- When the counter reaches DWELL-1 in SCAN:
  - shadow[SEL] takes the sample.
  - The counter clears.
  - If SEL < 3, SEL increments.
- When SEL = 3 and the counter reaches DWELL-1 (scan end):
  - DATA takes the full word, including the bit sampled on that same edge.
  - VALID = 1 for the following cycle.
  - SEL returns to 0.
  - If CONT = 1, state stays SCAN and the counter clears. Otherwise state goes to IDLE.
- ABORT = 1 in SCAN: on the next edge, state goes to IDLE and SEL = 0. DATA is unchanged, no VALID is issued and the shadow bits are discarded. ABORT has priority over scan end on the same edge.
- START while in SCAN is ignored. ABORT in IDLE has no effect.
- RST_N low mid-scan: all registers return to their reset values on that edge.

## Timing
- SEL is registered and changes only on CLK edges. The multiplexer therefore sees a stable select for exactly DWELL cycles per channel.
- START sampled at edge k gives scan-end edge k+4·DWELL. VALID is high in the cycle after that edge, together with the new DATA.
- In continuous mode, VALID strobes repeat every 4·DWELL cycles and no cycle is lost between scans.
- DWELL = 1 is legal: SEL steps every cycle.
- BUSY is low in the same cycle that VALID is high when CONT = 0. BUSY stays high when CONT = 1.

## Configuration
- MUX41_SCAN_MAJORITY_EN defined:
  - Takes three samples per channel, at counter values DWELL-3, DWELL-2 and DWELL-1.
  - Stores the 2-of-3 majority in shadow[SEL].
  - Adds a 2-bit vote accumulator.
  - DWELL < 3 is a configuration error, caught by an elaboration-time check.
- Not defined: a single sample per channel at counter value DWELL-1; no accumulator.
- Latency and all handshake behaviour are identical in both builds.

## Structure
- Shared package mux41_pkg holds:
  - state enum (IDLE, SCAN);
  - the constant NUM_CH = 4;
  - the select width constant SEL_W = 2.
- One natural sub-module, mux41_scan_cnt: the dwell counter with a terminal-count output and, when MUX41_SCAN_MAJORITY_EN is defined, the vote-window flags. The FSM, shadow register and output registers stay in mux41_scanner.
- The bench instantiates the 4:1 multiplexer between SEL and MUX_OUT, driven from a 4-bit IN vector.

## Test plan
- Single scan: reset, IN = 4'b1010, DWELL = 4, START pulse at edge 0. Expect SEL sequence 0,1,2,3 with 4 cycles each, VALID only in the cycle after edge 16, DATA = 4'b1010, BUSY low after edge 16.
- Continuous mode: CONT = 1, IN = 4'b0110 then IN = 4'b1001 applied mid-second-scan at channel 2. Expect VALID every 16 cycles; the second DATA mixes old and new bits per channel (4'b1110 for a change at the SEL = 2 boundary, by channel timing).
- Abort: ABORT at edge 9 of a scan with IN = 4'b1111 following a previous DATA = 4'b0000. Expect IDLE and SEL = 0 at edge 10, no VALID, DATA stays 4'b0000. ABORT asserted on the scan-end edge also yields no VALID.
- Reset mid-scan: RST_N low at edge 6. Expect SEL = 0, DATA = 0, VALID = 0, BUSY = 0 on that edge; a new START then gives a normal scan.
- DWELL = 1: IN = 4'b0011. Expect SEL stepping every cycle and VALID 4 cycles after START with DATA = 4'b0011.
- With MUX41_SCAN_MAJORITY_EN, DWELL = 4: a single-cycle glitch on IN[1] at counter value 1 of channel 1 still gives the correct majority bit, and DATA[1] is unaffected.
